cache_fill_responder: RTL and testbench

//  Memory-side responder for the cache<->arbiter line-fill protocol: accepts one

---
 rtl/cache_fill_responder.sv | 145 ++++++++++++++
 tb/tb_cache_fill_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_responder.sv
// cache_fill_responder
//   Memory-side responder for the cache line-fill protocol. Accepts one request
//   from a cache, acks it, reads the line-aligned block of 1<<LOGLINEOFFSET words
//   from a single-outstanding memory port, then returns the words as beats.
//
//   Ports
//     clk, reset            clock; asynchronous active-high reset
//     reqcyc/req/reqtag     cache request (req is a byte address, any word in line)
//     reqack                one-cycle accept pulse, the cycle after acceptance
//     respcyc/resp/resptag  response beat, transferred on respcyc && respack
//     respack               beat accept from cache
//     mem_rd/mem_addr       memory read command, held until mem_ready
//     mem_ready             command accept
//     mem_rvalid/mem_rdata  in-order read data, one per accepted command
//
//   Optional feature: define CACHE_FILL_STREAM_EN to overlap fetch and response,
//   presenting each beat as soon as its word has arrived.
module cache_fill_responder #(
  parameter int WORDSIZE      = 64,
  parameter int LOGLINEOFFSET = 3,
  parameter int TAGWIDTH      = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reqcyc,
  input  logic [WORDSIZE-1:0] req,
  input  logic [TAGWIDTH-1:0] reqtag,
  output logic                reqack,
  output logic                respcyc,
  output logic [WORDSIZE-1:0] resp,
  output logic [TAGWIDTH-1:0] resptag,
  input  logic                respack,
  output logic                mem_rd,
  output logic [WORDSIZE-1:0] mem_addr,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [WORDSIZE-1:0] mem_rdata
);
  localparam int N      = 1 << LOGLINEOFFSET;
  localparam int BYTESH = $clog2(WORDSIZE / 8);
  // Line alignment in byte-address terms: word offset plus byte-in-word bits.
  localparam int LINESH = LOGLINEOFFSET + BYTESH;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  state_t                     state, nextState;
  logic [WORDSIZE-1:0]        base;
  logic [TAGWIDTH-1:0]        tag;
  logic                       reqackR;
  // issueCnt counts to N inclusive; its MSB doubles as "all commands issued".
  logic [LOGLINEOFFSET:0]     issueCnt;
  logic [LOGLINEOFFSET-1:0]   rcvCnt;
  logic [LOGLINEOFFSET-1:0]   beatIdx;
  logic                       outstanding;
  logic [N-1:0]               lineValid;
  logic [WORDSIZE-1:0]        lineBuf [N];
  logic [WORDSIZE-1:0]        offs;

  logic accept, issueFire, rdataFire, lastRdata, respValid, beatFire, lastBeat;
  logic unusedReqOffset;

  // Offset bits of req never matter: fills are always line-aligned, 0..N-1.
  assign unusedReqOffset = ^req[LINESH-1:0];

  assign accept    = (state == IDLE) && reqcyc;
  assign mem_rd    = (state == FETCH) && !issueCnt[LOGLINEOFFSET] && !outstanding;
  assign issueFire = mem_rd && mem_ready;
  // Data with nothing outstanding is dropped here.
  assign rdataFire = mem_rvalid && outstanding;
  assign lastRdata = rdataFire && (rcvCnt == '1);

`ifdef CACHE_FILL_STREAM_EN
  assign respValid = ((state == FETCH) || (state == RESP)) && lineValid[beatIdx];
`else
  assign respValid = (state == RESP) && lineValid[beatIdx];
`endif

  assign beatFire = respValid && respack;
  assign lastBeat = beatFire && (beatIdx == '1);

  // Address wraps modulo 2^WORDSIZE; base is line-aligned so no line crossing.
  assign offs     = WORDSIZE'(issueCnt) << BYTESH;
  assign mem_addr = mem_rd ? (base + offs) : '0;

  // Data outputs are gated so nothing stale shows when no beat is presented.
  assign respcyc = respValid;
  assign resp    = respValid ? lineBuf[beatIdx] : '0;
  assign resptag = respValid ? tag : '0;
  assign reqack  = reqackR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (reqcyc)    nextState = FETCH;
      FETCH:   if (lastRdata) nextState = RESP;
      RESP:    if (lastBeat)  nextState = IDLE;
      default:                nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base        <= '0;
      tag         <= '0;
      reqackR     <= 1'b0;
      issueCnt    <= '0;
      rcvCnt      <= '0;
      beatIdx     <= '0;
      outstanding <= 1'b0;
      lineValid   <= '0;
    end else begin
      reqackR <= 1'b0;
      if (accept) begin
        base        <= {req[WORDSIZE-1:LINESH], {LINESH{1'b0}}};
        tag         <= reqtag;
        reqackR     <= 1'b1;
        issueCnt    <= '0;
        rcvCnt      <= '0;
        beatIdx     <= '0;
        outstanding <= 1'b0;
        lineValid   <= '0;
      end
      if (issueFire) begin
        issueCnt    <= issueCnt + 1'b1;
        outstanding <= 1'b1;
      end
      if (rdataFire) begin
        rcvCnt            <= rcvCnt + 1'b1;
        lineValid[rcvCnt] <= 1'b1;
        outstanding       <= 1'b0;
      end
      if (beatFire) beatIdx <= beatIdx + 1'b1;
    end
  end

  // Line storage needs no reset: every read is qualified by lineValid.
  always_ff @(posedge clk) begin
    if (rdataFire) lineBuf[rcvCnt] <= mem_rdata;
  end
endmodule

// File: tb/tb_cache_fill_responder.sv
module tb_cache_fill_responder;
  logic        clk, reset;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack, respcyc, respack;
  logic [63:0] resp;
  logic [12:0] resptag;
  logic        mem_rd, mem_ready, mem_rvalid;
  logic [63:0] mem_addr, mem_rdata;

  cache_fill_responder dut (
    .clk(clk), .reset(reset), .reqcyc(reqcyc), .req(req), .reqtag(reqtag),
    .reqack(reqack), .respcyc(respcyc), .resp(resp), .resptag(resptag),
    .respack(respack), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [63:0] d; logic [12:0] t; } beat_t;
  typedef struct { logic [63:0] a; int due; } pend_t;

  beat_t       beatQ[$];
  logic [63:0] addrQ[$];
  int          acceptQ[$];

  int checks = 0, failures = 0;
  int memLat = 2, spurReq = 0, spurDone = 0, timeouts = 0;
  bit latTest = 0, done = 0;
  int beatCnt = 0, fireCnt = 0;

  // ---------------- memory model: returns address as data ----------------
  initial begin
    pend_t pendQ[$];
    int    cyc;
    bit    fire;
    logic [63:0] faddr;
    cyc = 0;
    mem_rvalid = 0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      fire  = mem_rd && mem_ready && !reset;
      faddr = mem_addr;
      @(posedge clk);
      #1;
      cyc++;
      mem_rvalid = 0;
      mem_rdata  = '0;
      if (reset) pendQ.delete();
      else begin
        if (fire) pendQ.push_back('{faddr, cyc + memLat - 1});
        if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
          mem_rvalid = 1;
          mem_rdata  = pendQ[0].a;
          void'(pendQ.pop_front());
        end else if (pendQ.size() == 0 && spurReq != spurDone) begin
          mem_rvalid = 1;
          mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
          spurDone++;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    int    ncyc, firstResp, lastRv, eighthFire;
    bit    sawResp, prevAck, chkDrop, expAck, prevRdStall, prevBeatStall;
    logic [63:0] prevAddr, prevResp;
    logic [12:0] prevTag;
    beat_t eb;
    logic [63:0] ea;
    ncyc = 0; firstResp = 0; lastRv = 0; eighthFire = 0;
    sawResp = 0; prevAck = 0; chkDrop = 0; expAck = 0;
    prevRdStall = 0; prevBeatStall = 0;
    prevAddr = '0; prevResp = '0; prevTag = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (ncyc > 20000) begin
        chk(0, "watchdog", 64'(ncyc), 64'd20000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      if (reset) begin
        chk((resp | mem_addr | {48'd0, resptag, reqack, respcyc, mem_rd}) == 0,
            "reset_outputs_zero", resp | mem_addr | {48'd0, resptag, reqack, respcyc, mem_rd}, 64'd0);
        beatQ.delete(); addrQ.delete(); acceptQ.delete();
        prevAck = 0; chkDrop = 0; expAck = 0; prevRdStall = 0; prevBeatStall = 0;
        beatCnt = 0; fireCnt = 0; sawResp = 0;
      end else if (done) begin
        chk(beatQ.size() == 0 && addrQ.size() == 0 && acceptQ.size() == 0, "queues_drained",
            64'(beatQ.size() + addrQ.size() + acceptQ.size()), 64'd0);
        chk(timeouts == 0, "no_timeouts", 64'(timeouts), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end else begin
        if (expAck) begin
          chk(reqack == 1'b1, "held_req_acked_after_idle", 64'(reqack), 64'd1);
          expAck = 0;
        end
        if (reqack) begin
          chk(!prevAck, "reqack_single_pulse", 64'(prevAck), 64'd0);
          chk(acceptQ.size() > 0 && beatQ.size() == 8 * acceptQ.size(), "reqack_timing",
              64'(beatQ.size()), 64'(8 * acceptQ.size()));
          if (acceptQ.size() > 0) void'(acceptQ.pop_front());
          beatCnt = 0; fireCnt = 0; sawResp = 0;
        end
        prevAck = reqack;
        if (chkDrop) begin
          chk(respcyc == 1'b0, "respcyc_low_after_last_beat", 64'(respcyc), 64'd0);
          if (reqcyc) expAck = 1;
          chkDrop = 0;
        end
        if (prevRdStall)
          chk(mem_rd && mem_addr == prevAddr, "mem_cmd_held", mem_addr, prevAddr);
        if (prevBeatStall)
          chk(respcyc && resp == prevResp && resptag == prevTag, "beat_held", resp, prevResp);
        prevRdStall   = mem_rd && !mem_ready;
        prevAddr      = mem_addr;
        prevBeatStall = respcyc && !respack;
        prevResp      = resp;
        prevTag       = resptag;
        if (mem_rvalid) lastRv = ncyc;
        if (respcyc && !sawResp) begin
          firstResp = ncyc;
          sawResp   = 1;
        end
        if (mem_rd && mem_ready) begin
          fireCnt++;
          if (fireCnt == 8) eighthFire = ncyc;
          if (addrQ.size() == 0) chk(0, "unexpected_mem_cmd", mem_addr, 64'd0);
          else begin
            ea = addrQ.pop_front();
            chk(mem_addr == ea, "mem_addr", mem_addr, ea);
          end
        end
        if (respcyc && respack) begin
          if (beatQ.size() == 0) chk(0, "unexpected_beat", resp, 64'd0);
          else begin
            eb = beatQ.pop_front();
            chk(resp == eb.d, "beat_data", resp, eb.d);
            chk(resptag == eb.t, "beat_tag", 64'(resptag), 64'(eb.t));
          end
          beatCnt++;
          if (beatCnt == 8) begin
            chkDrop = 1;
            if (latTest) begin
`ifdef CACHE_FILL_STREAM_EN
              chk(firstResp < eighthFire, "stream_first_resp_before_8th_rd",
                  64'(firstResp), 64'(eighthFire));
`else
              chk(firstResp > lastRv, "first_resp_after_8th_rvalid",
                  64'(firstResp), 64'(lastRv));
`endif
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pushExp(input logic [63:0] expBase, input logic [12:0] tg);
    acceptQ.push_back(1);
    for (int k = 0; k < 8; k++) begin
      beatQ.push_back('{expBase + 64'(k * 8), tg});
      addrQ.push_back(expBase + 64'(k * 8));
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [12:0] tg, input logic [63:0] expBase);
    bit got;
    got = 0;
    reqcyc = 1; req = a; reqtag = tg;
    pushExp(expBase, tg);
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      got = reqack;
    end
    reqcyc = 0;
    if (!got) timeouts++;
  endtask

  task automatic waitIdle(input bit toggle);
    bit idle;
    idle = 0;
    for (int i = 0; i < 600 && !idle; i++) begin
      @(posedge clk); #1;
      if (toggle) respack = ~respack;
      idle = (beatQ.size() == 0 && acceptQ.size() == 0);
    end
    if (!idle) timeouts++;
    respack = 1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bit got;
    reset = 1; reqcyc = 0; req = '0; reqtag = '0; respack = 1; mem_ready = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;

    // basic fill, word offset inside line ignored
    issue(64'h1238, 13'h05, 64'h1200);
    waitIdle(0);

    // respack toggling
    issue(64'h3A10, 13'h1A, 64'h3A00);
    waitIdle(1);

    // memory back-pressure on third command, plus a spurious rvalid while idle-port
    issue(64'h1238, 13'h07, 64'h1200);
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      got = (fireCnt == 2);
    end
    if (!got) timeouts++;
    mem_ready = 0;
    spurReq++;
    repeat (5) @(posedge clk);
    #1 mem_ready = 1;
    waitIdle(0);

    // second request during FETCH is held off until the IDLE cycle
    issue(64'h1238, 13'h01, 64'h1200);
    repeat (3) @(posedge clk);
    #1;
    reqcyc = 1; req = 64'h4000; reqtag = 13'h0A;
    pushExp(64'h4000, 13'h0A);
    got = 0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge clk); #1;
      got = reqack;
    end
    reqcyc = 0;
    if (!got) timeouts++;
    waitIdle(0);

    // reset mid-response, then a clean fill
    issue(64'h5008, 13'h11, 64'h5000);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      got = (beatCnt == 3);
    end
    if (!got) timeouts++;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(posedge clk); #1;
    issue(64'h80, 13'h02, 64'h80);
    waitIdle(0);

    // top of address space
    issue(64'hFFFF_FFFF_FFFF_FFC7, 13'h0000, 64'hFFFF_FFFF_FFFF_FFC0);
    waitIdle(0);

    // latency relationship with slow memory
    memLat = 4;
    latTest = 1;
    issue(64'h2A48, 13'h1FFF, 64'h2A40);
    waitIdle(0);
    latTest = 0;

    done = 1;
    forever @(posedge clk);
  end
endmodule
